// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite slave-port bundle for axi_lite_reg_slave: five channels, master and slave views.
// Handshake rule on every channel: a transfer happens on the rising edge where valid and ready
// are both 1; the source holds payload and valid steady until then and never waits on ready.
interface axi_lite_reg_slave_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic                  s_awvalid;
  logic                  s_awready;
  logic [31:0]           s_wdata;
  logic [3:0]            s_wstrb;
  logic                  s_wvalid;
  logic                  s_wready;
  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [31:0]           s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS x 32-bit read/write registers with byte strobes,
// AW/W accepted in either order, SLVERR on out-of-range addresses, flat register view.
module axi_lite_reg_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           aclk,
  input  logic                           areset_n,
  axi_lite_reg_slave_if.slave            bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [1:0]                     w_state_dbg,
  output logic                           r_state_dbg
);
  localparam int IW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_RESP}                 r_state_e;

  w_state_e w_state;
  r_state_e r_state;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  commit_en;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [STRB_W-1:0]     commit_strb;
  logic [ADDR_WIDTH-1:0] c_off, r_off;
  logic                  c_hit, r_hit;
  logic [IW-1:0]         c_idx, r_idx;

  assign aw_hs = bus.s_awvalid & bus.s_awready;
  assign w_hs  = bus.s_wvalid  & bus.s_wready;
  assign ar_hs = bus.s_arvalid & bus.s_arready;

  // The write commits on the later of the two handshakes; pick the half that was held.
  always_comb begin
    commit_en   = 1'b0;
    commit_addr = bus.s_awaddr;
    commit_data = bus.s_wdata;
    commit_strb = bus.s_wstrb;
    case (w_state)
      W_IDLE: commit_en = aw_hs & w_hs;
      W_ADDR: begin
        commit_en   = w_hs;
        commit_addr = aw_addr_q;
      end
      W_DATA: begin
        commit_en   = aw_hs;
        commit_data = wdata_q;
        commit_strb = wstrb_q;
      end
      default: commit_en = 1'b0;
    endcase
  end

  // Word offset from the base; the sub-word address bits fall away in the shift.
  assign c_off = (commit_addr - BASE_ADDR) >> 2;
  assign c_hit = (commit_addr >= BASE_ADDR) && (c_off < ADDR_WIDTH'(NUM_REGS));
  assign c_idx = c_off[IW-1:0];
  assign r_off = (bus.s_araddr - BASE_ADDR) >> 2;
  assign r_hit = (bus.s_araddr >= BASE_ADDR) && (r_off < ADDR_WIDTH'(NUM_REGS));
  assign r_idx = r_off[IW-1:0];

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_state       <= W_IDLE;
      bus.s_awready <= 1'b0;
      bus.s_wready  <= 1'b0;
      bus.s_bvalid  <= 1'b0;
      bus.s_bresp   <= 2'b00;
      aw_addr_q     <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_en && c_hit && (c_idx == IW'(i))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (commit_strb[b]) regs[i][8*b +: 8] <= commit_data[8*b +: 8];
          end
        end
      end
      if (commit_en) begin
        bus.s_awready <= 1'b0;
        bus.s_wready  <= 1'b0;
        bus.s_bvalid  <= 1'b1;
        bus.s_bresp   <= c_hit ? 2'b00 : 2'b10;
        w_state       <= W_RESP;
      end else begin
        case (w_state)
          W_IDLE: begin
            if (aw_hs) begin
              aw_addr_q     <= bus.s_awaddr;
              bus.s_awready <= 1'b0;
              bus.s_wready  <= 1'b1;
              w_state       <= W_ADDR;
            end else if (w_hs) begin
              wdata_q       <= bus.s_wdata;
              wstrb_q       <= bus.s_wstrb;
              bus.s_awready <= 1'b1;
              bus.s_wready  <= 1'b0;
              w_state       <= W_DATA;
            end else begin
              bus.s_awready <= 1'b1;
              bus.s_wready  <= 1'b1;
            end
          end
          W_RESP: begin
            if (bus.s_bready) begin
              bus.s_bvalid  <= 1'b0;
              bus.s_awready <= 1'b1;
              bus.s_wready  <= 1'b1;
              w_state       <= W_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Registers update by NBA, so a same-edge read sees the pre-write value.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state       <= R_IDLE;
      bus.s_arready <= 1'b0;
      bus.s_rvalid  <= 1'b0;
      bus.s_rdata   <= '0;
      bus.s_rresp   <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            bus.s_arready <= 1'b0;
            bus.s_rvalid  <= 1'b1;
            bus.s_rdata   <= r_hit ? regs[r_idx] : '0;
            bus.s_rresp   <= r_hit ? 2'b00 : 2'b10;
            r_state       <= R_RESP;
          end else begin
            bus.s_arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (bus.s_rready) begin
            bus.s_rvalid  <= 1'b0;
            bus.s_arready <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: scenario tasks, response scoreboards, reference register model.
module tb_axi_lite_reg_slave;
  localparam int          AW   = 32;
  localparam int          NR   = 16;
  localparam logic [31:0] BASE = 32'h0000_1000;

  // ---------------- clock / reset ----------------
  logic            aclk = 1'b0;
  logic            areset_n = 1'b0;
  logic [NR*32-1:0] reg_out;
  logic [1:0]      w_state_dbg;
  logic            r_state_dbg;

  axi_lite_reg_slave_if #(.ADDR_WIDTH(AW)) bus ();

  axi_lite_reg_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_REGS(NR), .BASE_ADDR(BASE)
  ) dut (
    .aclk(aclk), .areset_n(areset_n), .bus(bus),
    .reg_out(reg_out), .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard and model ----------------
  logic [1:0]  b_exp_q[$];
  logic [33:0] r_exp_q[$];
  logic [31:0] model_regs [NR];

  function automatic bit model_hit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(NR * 4));
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    int idx;
    if (!model_hit(a)) return 2'b10;
    idx = int'((a - BASE) / 4);
    for (int b = 0; b < 4; b++) if (s[b]) model_regs[idx][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] a);
    if (!model_hit(a)) return {2'b10, 32'h0};
    return {2'b00, model_regs[int'((a - BASE) / 4)]};
  endfunction

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] f;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = model_regs[i];
    return f;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NR; i++) model_regs[i] = 32'h0;
  endfunction

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic send(input bit do_aw, input bit do_w, input bit do_ar,
                      input logic [31:0] waddr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic [31:0] raddr);
    int n = 0;
    bus.s_awaddr = waddr; bus.s_wdata = wdata; bus.s_wstrb = wstrb; bus.s_araddr = raddr;
    bus.s_awvalid = do_aw; bus.s_wvalid = do_w; bus.s_arvalid = do_ar;
    while (((do_aw && !bus.s_awready) || (do_w && !bus.s_wready) || (do_ar && !bus.s_arready))
           && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (n == 20) begin
      checks++; errors++;
      $display("FAIL send_timeout: ready not seen within 20 cycles (aw=%0b w=%0b ar=%0b)",
               do_aw, do_w, do_ar);
    end
    @(negedge aclk);
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
  endtask

  task automatic get_b(output logic [1:0] resp);
    int n = 0;
    bus.s_bready = 1'b1;
    while (!bus.s_bvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (n == 20) begin
      checks++; errors++;
      $display("FAIL b_timeout: bvalid not seen within 20 cycles");
      resp = 2'bxx;
    end else begin
      resp = bus.s_bresp;
    end
    @(negedge aclk);
    bus.s_bready = 1'b0;
  endtask

  task automatic get_r(output logic [33:0] rsp);
    int n = 0;
    bus.s_rready = 1'b1;
    while (!bus.s_rvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    if (n == 20) begin
      checks++; errors++;
      $display("FAIL r_timeout: rvalid not seen within 20 cycles");
      rsp = 'x;
    end else begin
      rsp = {bus.s_rresp, bus.s_rdata};
    end
    @(negedge aclk);
    bus.s_rready = 1'b0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    areset_n = 1'b0;
    @(negedge aclk);
    checks++;
    if ({bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hs: got %b want 00000",
               {bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid});
    end
    checks++;
    if ({bus.s_bresp, bus.s_rresp, bus.s_rdata} !== 36'h0) begin
      errors++;
      $display("FAIL reset_resp: got %h want 0", {bus.s_bresp, bus.s_rresp, bus.s_rdata});
    end
    checks++;
    if (reg_out !== '0) begin errors++; $display("FAIL reset_regs: got %h want 0", reg_out); end
    checks++;
    if ({w_state_dbg, r_state_dbg} !== 3'b000) begin
      errors++; $display("FAIL reset_state: got %b want 000", {w_state_dbg, r_state_dbg});
    end
    areset_n = 1'b1;
    #1;
    checks++;
    if ({bus.s_awready, bus.s_wready, bus.s_arready} !== 3'b000) begin
      errors++; $display("FAIL ready_before_edge: got %b want 000",
                         {bus.s_awready, bus.s_wready, bus.s_arready});
    end
    @(negedge aclk);
    checks++;
    if ({bus.s_awready, bus.s_wready, bus.s_arready} !== 3'b111) begin
      errors++; $display("FAIL ready_after_edge: got %b want 111",
                         {bus.s_awready, bus.s_wready, bus.s_arready});
    end
  endtask

  task automatic test_same_cycle_write();
    logic [1:0] resp, exp;
    b_exp_q.push_back(model_write(BASE + 32'h8, 32'hDEADBEEF, 4'hF));
    send(1, 1, 0, BASE + 32'h8, 32'hDEADBEEF, 4'hF, 32'h0);
    checks++;
    if (bus.s_bvalid !== 1'b1) begin errors++; $display("FAIL b_latency: bvalid=%b want 1", bus.s_bvalid); end
    checks++;
    if (reg_out[95:64] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL reg2_write: got %h want deadbeef", reg_out[95:64]);
    end
    get_b(resp);
    exp = b_exp_q.pop_front();
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL bresp_same_cycle: got %b want %b", resp, exp); end
  endtask

  task automatic test_w_first();
    logic [1:0] resp, exp;
    b_exp_q.push_back(model_write(BASE + 32'h4, 32'h12345678, 4'b0101));
    send(0, 1, 0, 32'h0, 32'h12345678, 4'b0101, 32'h0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({bus.s_awready, bus.s_wready, w_state_dbg} !== 4'b1010) begin
        errors++; $display("FAIL w_first_wait: awready/wready/state=%b want 1010",
                           {bus.s_awready, bus.s_wready, w_state_dbg});
      end
      @(negedge aclk);
    end
    send(1, 0, 0, BASE + 32'h4, 32'h0, 4'h0, 32'h0);
    checks++;
    if (reg_out[63:32] !== 32'h00340078) begin
      errors++; $display("FAIL reg1_strobe: got %h want 00340078", reg_out[63:32]);
    end
    get_b(resp);
    exp = b_exp_q.pop_front();
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL bresp_w_first: got %b want %b", resp, exp); end
  endtask

  task automatic test_aw_first();
    logic [1:0] resp, exp;
    b_exp_q.push_back(model_write(BASE + 32'h14, 32'hCAFEF00D, 4'b1010));
    send(1, 0, 0, BASE + 32'h14, 32'h0, 4'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({bus.s_awready, bus.s_wready, w_state_dbg} !== 4'b0101) begin
        errors++; $display("FAIL aw_first_wait: awready/wready/state=%b want 0101",
                           {bus.s_awready, bus.s_wready, w_state_dbg});
      end
      @(negedge aclk);
    end
    send(0, 1, 0, 32'h0, 32'hCAFEF00D, 4'b1010, 32'h0);
    checks++;
    if (reg_out[191:160] !== 32'hCA00F000) begin
      errors++; $display("FAIL reg5_strobe: got %h want ca00f000", reg_out[191:160]);
    end
    get_b(resp);
    exp = b_exp_q.pop_front();
    checks++;
    if (resp !== exp) begin errors++; $display("FAIL bresp_aw_first: got %b want %b", resp, exp); end
  endtask

  task automatic test_read_hold();
    logic [33:0] rsp, exp;
    r_exp_q.push_back(model_read(BASE + 32'h8));
    send(0, 0, 1, 32'h0, 32'h0, 4'h0, BASE + 32'h8);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({bus.s_rvalid, bus.s_arready, bus.s_rresp, bus.s_rdata} !== {2'b10, r_exp_q[0]}) begin
        errors++; $display("FAIL read_hold: rvalid/arready/resp/data=%h want %h",
                           {bus.s_rvalid, bus.s_arready, bus.s_rresp, bus.s_rdata},
                           {2'b10, r_exp_q[0]});
      end
      @(negedge aclk);
    end
    get_r(rsp);
    exp = r_exp_q.pop_front();
    checks++;
    if (rsp !== exp) begin errors++; $display("FAIL read_reg2: got %h want %h", rsp, exp); end
    checks++;
    if (bus.s_arready !== 1'b1) begin errors++; $display("FAIL arready_after_r: got %b want 1", bus.s_arready); end
  endtask

  task automatic test_miss();
    logic [1:0]  resp, bexp;
    logic [33:0] rsp, rexp;
    logic [31:0] addrs [2];
    addrs[0] = BASE + 32'(NR * 4);
    addrs[1] = BASE - 32'h4;
    b_exp_q.push_back(model_write(addrs[0], 32'hFFFFFFFF, 4'hF));
    send(1, 1, 0, addrs[0], 32'hFFFFFFFF, 4'hF, 32'h0);
    get_b(resp);
    bexp = b_exp_q.pop_front();
    checks++;
    if (resp !== bexp) begin errors++; $display("FAIL bresp_miss: got %b want %b", resp, bexp); end
    checks++;
    if (reg_out !== model_flat()) begin errors++; $display("FAIL miss_regs: got %h want %h", reg_out, model_flat()); end
    foreach (addrs[k]) begin
      r_exp_q.push_back(model_read(addrs[k]));
      send(0, 0, 1, 32'h0, 32'h0, 4'h0, addrs[k]);
      get_r(rsp);
      rexp = r_exp_q.pop_front();
      checks++;
      if (rsp !== rexp) begin errors++; $display("FAIL read_miss: addr %h got %h want %h", addrs[k], rsp, rexp); end
    end
  endtask

  task automatic test_same_edge_rw();
    logic [1:0]  resp, bexp;
    logic [33:0] rsp, rexp;
    r_exp_q.push_back(model_read(BASE + 32'hC));
    b_exp_q.push_back(model_write(BASE + 32'hC, 32'hA5A5A5A5, 4'hF));
    send(1, 1, 1, BASE + 32'hC, 32'hA5A5A5A5, 4'hF, BASE + 32'hC);
    get_r(rsp);
    rexp = r_exp_q.pop_front();
    checks++;
    if (rsp !== rexp) begin errors++; $display("FAIL same_edge_read: got %h want %h", rsp, rexp); end
    get_b(resp);
    bexp = b_exp_q.pop_front();
    checks++;
    if (resp !== bexp) begin errors++; $display("FAIL same_edge_bresp: got %b want %b", resp, bexp); end
    r_exp_q.push_back(model_read(BASE + 32'hC));
    send(0, 0, 1, 32'h0, 32'h0, 4'h0, BASE + 32'hC);
    get_r(rsp);
    rexp = r_exp_q.pop_front();
    checks++;
    if (rsp !== rexp) begin errors++; $display("FAIL reread_reg3: got %h want %h", rsp, rexp); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  resp, bexp;
    logic [33:0] rsp, rexp;
    logic [31:0] a, d;
    logic [3:0]  s;
    for (int k = 0; k < 12; k++) begin
      a = BASE + 32'(4 * $urandom_range(0, NR)) + 32'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      b_exp_q.push_back(model_write(a, d, s));
      send(1, 1, 0, a, d, s, 32'h0);
      get_b(resp);
      bexp = b_exp_q.pop_front();
      checks++;
      if (resp !== bexp) begin errors++; $display("FAIL b2b_bresp: addr %h got %b want %b", a, resp, bexp); end
    end
    for (int i = 0; i < NR; i++) begin
      a = BASE + 32'(4 * i);
      r_exp_q.push_back(model_read(a));
      send(0, 0, 1, 32'h0, 32'h0, 4'h0, a);
      get_r(rsp);
      rexp = r_exp_q.pop_front();
      checks++;
      if (rsp !== rexp) begin errors++; $display("FAIL b2b_read: reg %0d got %h want %h", i, rsp, rexp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp, bexp;
    send(0, 0, 1, 32'h0, 32'h0, 4'h0, BASE + 32'h8);
    send(1, 0, 0, BASE + 32'h0, 32'h0, 4'h0, 32'h0);
    checks++;
    if ({w_state_dbg, bus.s_rvalid} !== 3'b011) begin
      errors++; $display("FAIL mid_setup: state/rvalid=%b want 011", {w_state_dbg, bus.s_rvalid});
    end
    #2 areset_n = 1'b0;
    #1;
    checks++;
    if ({bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid, bus.s_rvalid,
         bus.s_bresp, bus.s_rresp, bus.s_rdata, w_state_dbg, r_state_dbg} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: not all zero (rdata=%h rvalid=%b)",
                         bus.s_rdata, bus.s_rvalid);
    end
    checks++;
    if (reg_out !== '0) begin errors++; $display("FAIL mid_reset_regs: got %h want 0", reg_out); end
    model_clear();
    @(negedge aclk);
    areset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      checks++;
      if ({bus.s_bvalid, bus.s_rvalid} !== 2'b00) begin
        errors++; $display("FAIL stale_resp: bvalid/rvalid=%b want 00", {bus.s_bvalid, bus.s_rvalid});
      end
    end
    b_exp_q.push_back(model_write(BASE, 32'h11223344, 4'hF));
    send(1, 1, 0, BASE, 32'h11223344, 4'hF, 32'h0);
    get_b(resp);
    bexp = b_exp_q.pop_front();
    checks++;
    if (resp !== bexp) begin errors++; $display("FAIL post_reset_bresp: got %b want %b", resp, bexp); end
    checks++;
    if (reg_out[31:0] !== 32'h11223344) begin
      errors++; $display("FAIL post_reset_reg0: got %h want 11223344", reg_out[31:0]);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b0;
    model_clear();
    @(negedge aclk);
    test_reset();
    test_same_cycle_write();
    test_w_first();
    test_aw_first();
    test_read_hold();
    test_miss();
    test_same_edge_rw();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (reg_out !== model_flat()) begin errors++; $display("FAIL final_regs: got %h want %h", reg_out, model_flat()); end
    checks++;
    if ((b_exp_q.size() + r_exp_q.size()) != 0) begin
      errors++; $display("FAIL scoreboard_left: %0d entries remain want 0", b_exp_q.size() + r_exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_lite_reg_slave.md
# axi_lite_reg_slave

AXI4-Lite responder that implements a bank of `NUM_REGS` read/write 32-bit registers behind one slave port of the AXI4-Lite interconnect. It is the slave-side counterpart to `axi_lite_master`. It accepts write-address and write-data in either order and applies byte strobes. It returns OKAY/SLVERR responses and exposes all register contents as a flat output bus for downstream logic and scoreboard checks.

## Interface
- `ADDR_WIDTH`, default 32: width of AWADDR/ARADDR.
- `DATA_WIDTH`, default 32: data width. Fixed to 32; other values are unsupported.
- `NUM_REGS`, default 16: number of registers. Range 1..256.
- `BASE_ADDR`, default 32'h0000_0000: byte address of register 0. Must be 4-byte aligned.
- `aclk` in 1: single clock. All signals are sampled on the rising edge.
- `areset_n` in 1: reset, asynchronous and active-low.
- `s_awaddr` in ADDR_WIDTH, `s_awvalid` in 1, `s_awready` out 1: write-address channel.
- `s_wdata` in 32, `s_wstrb` in 4, `s_wvalid` in 1, `s_wready` out 1: write-data channel.
- `s_bresp` out 2, `s_bvalid` out 1, `s_bready` in 1: write-response channel.
- `s_araddr` in ADDR_WIDTH, `s_arvalid` in 1, `s_arready` out 1: read-address channel.
- `s_rdata` out 32, `s_rresp` out 2, `s_rvalid` out 1, `s_rready` in 1: read-data channel.
- `reg_out` out NUM_REGS*32: current register contents. Register i occupies bits [32i+31:32i].

## Operation
- Address decode:
  - Offset = addr − BASE_ADDR. Address bits [1:0] are ignored.
  - Index = offset >> 2.
  - The address is a hit when addr ≥ BASE_ADDR and index < NUM_REGS. Any other address is a miss.
- Write FSM states: W_IDLE, W_ADDR (AW held, waiting for W), W_DATA (W held, waiting for AW), W_RESP.
  - W_IDLE: `s_awready`=1 and `s_wready`=1.
    - AW and W handshakes in the same cycle → commit the write, go to W_RESP.
    - AW only → latch the address, go to W_ADDR.
    - W only → latch data and strobe, go to W_DATA.
  - W_ADDR: `s_awready`=0, `s_wready`=1. A W handshake commits the write and moves to W_RESP.
  - W_DATA: `s_wready`=0, `s_awready`=1. An AW handshake commits the write and moves to W_RESP.
  - W_RESP: both readies are 0 and `s_bvalid`=1. `s_bvalid` is held until `s_bready`=1, then the FSM returns to W_IDLE.
- Commit rules:
  - Hit: for each byte lane b with `wstrb[b]`=1, register[index] byte b takes wdata byte b. Lanes with strobe 0 are unchanged. BRESP=2'b00.
  - Miss: no register changes. BRESP=2'b10 (SLVERR).
- Read FSM states: R_IDLE and R_RESP.
  - R_IDLE: `s_arready`=1. An AR handshake captures the data and response, then moves to R_RESP.
    - Hit: RDATA = register[index], RRESP=2'b00.
    - Miss: RDATA = 0, RRESP=2'b10.
  - R_RESP: `s_arready`=0 and `s_rvalid`=1. RDATA and RRESP are held stable until `s_rready`=1, then the FSM returns to R_IDLE.
- The read and write paths are fully independent and may be active in the same cycle.
- All readies, valids, response codes and `s_rdata` are registered outputs.

## Timing
- Reset (asynchronous assertion, release synchronous to `aclk`):
  - All registers and `reg_out` = 0.
  - `s_awready`, `s_wready`, `s_arready`, `s_bvalid`, `s_rvalid` = 0. `s_bresp`, `s_rresp`, `s_rdata` = 0.
  - Both FSMs go to their IDLE state.
  - Readies rise at the first `aclk` edge after `areset_n` is released.
- Write latency: registers update at the edge of the later of the AW/W handshakes. `s_bvalid` rises in the following cycle.
- Read latency: the AR handshake at edge N drives `s_rvalid`=1 from edge N onward, valid in cycle N+1.
- Throughput: at most one transaction per 2 cycles on each path, because readies drop while a response is pending. With `s_bready`/`s_rready` held high, each path completes one transaction every 2 cycles.
- Same-edge read and write to one register: the read returns the pre-write value. The write is visible to any AR accepted on a later edge.
- `reg_out` reflects a committed write in the cycle after the commit edge.
- A new AW/W/AR is never accepted while its response is pending. There is no outstanding-transaction buffering.
- Reset asserted mid-transaction: the transaction is dropped, no response is issued, and the full reset state is applied.

## Test plan
- Reset, then AW+W in the same cycle: addr BASE+0x8, data 32'hDEADBEEF, strb 4'hF → BVALID one cycle later with BRESP=00, `reg_out[95:64]`=DEADBEEF.
- W first, AW three cycles later: addr BASE+0x4, data 32'h12345678, strb 4'b0101 → reg1=32'h00340078, OKAY. AWREADY=1 and WREADY=0 while waiting. Repeat with AW first.
- Read BASE+0x8 with RREADY held low for 4 cycles → RVALID=1, RDATA=DEADBEEF, RRESP=00 stable throughout, ARREADY=0 until the R handshake completes.
- Write and read at address BASE+NUM_REGS*4 → BRESP=10 with no register changed; RRESP=10 with RDATA=0.
- Same-cycle AR and AW+W to reg3 (old 0, new 32'hA5A5A5A5) → RDATA=0. A following read returns A5A5A5A5.
- Assert `areset_n` while in W_ADDR and while RVALID=1 → all outputs 0 immediately, no B/R response, registers cleared. A normal write succeeds after release.
